// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared types and defaults for the single-step / free-run processor clock controller.
// Also provides the counter-width helper used by the top and the button debouncer.
package cpu_clock_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam int unsigned DEF_HALF_PERIOD     = 25_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
    localparam int unsigned DEF_CNT_W           = 8;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_clock_ctrl_btn.sv
// Active-low push-button conditioner: 2-flop synchronizer, stability debounce,
// and a one-cycle press_evt on each accepted press.
module btn_debounce
    import cpu_clock_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press_evt
);

    localparam int unsigned       CW     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]     C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          btn_s1;
    logic          btn_s;
    logic          btn_db;
    logic [CW-1:0] cnt;

    // A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1    <= 1'b1;
            btn_s     <= 1'b1;
            btn_db    <= 1'b1;
            cnt       <= '0;
            press_evt <= 1'b0;
        end else begin
            btn_s1    <= btn_n;
            btn_s     <= btn_s1;
            press_evt <= 1'b0;
            if (btn_s != btn_db) begin
                if (cnt == C_LAST) begin
                    btn_db    <= btn_s;
                    cnt       <= '0;
                    press_evt <= ~btn_s;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Processor clock generator: free-running square wave in run mode, one full
// cpu_clk cycle per debounced button press in step mode, plus a rise counter.
module cpu_clock_ctrl
    import cpu_clock_ctrl_pkg::*;
#(
    parameter int unsigned HALF_PERIOD     = DEF_HALF_PERIOD,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_btn_n,
    input  logic             run_sw,
    output logic             cpu_clk,
    output logic             cpu_rise,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned   TW     = cnt_width(HALF_PERIOD);
    localparam logic [TW-1:0] T_LAST = TW'(HALF_PERIOD - 1);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          enter_high;
    logic          run_s1;
    logic          run_q;
    logic          press_evt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (step_btn_n),
        .press_evt (press_evt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            run_s1 <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            run_s1 <= run_sw;
            run_q  <= run_s1;
        end
    end

    // Presses arriving outside S_IDLE are dropped, never queued.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = '0;
        enter_high = 1'b0;
        case (state)
            S_IDLE: begin
                if (run_q || press_evt) begin
                    state_nxt  = S_HIGH;
                    enter_high = 1'b1;
                end
            end
            S_HIGH: begin
                if (timer == T_LAST) begin
                    state_nxt = S_LOW;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_LOW: begin
                if (timer == T_LAST) begin
                    if (run_q) begin
                        state_nxt  = S_HIGH;
                        enter_high = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            cpu_clk     <= 1'b0;
            cpu_rise    <= 1'b0;
            busy        <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            cpu_clk     <= (state_nxt == S_HIGH);
            cpu_rise    <= enter_high;
            busy        <= (state_nxt != S_IDLE);
            cycle_count <= cycle_count + CNT_W'(enter_high);
        end
    end

endmodule
